mem_stall_ctrl: RTL and testbench

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/mem_stall_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
// Holds the pipeline while the M-stage load/store completes a handshake with
// the data memory. It bubbles MEM/WB until the ack arrives and captures the
// load data for the MEM/WB read-data input.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles. An abort sets the sticky err flag, returns
// rd = 0 and lets the instruction retire.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   memread_m, memwrite_m      M-stage load / store
//   aluresult_m, writedata_m   M-stage address / store data
//   dmem_req/we/addr/wdata     data-memory request channel
//   dmem_ack, dmem_rdata       data-memory completion and load data
//   rd                         captured load data
//   stall_f/d/e/m              hold PC, IF/ID, ID/EX, EX/MEM
//   flush_w                    bubble into MEM/WB
//   busy                       FSM not in IDLE
//   stall_cycles               saturating count of stalled cycles
//   err                        sticky timeout flag
// -----------------------------------------------------------------------------
module mem_stall_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memread_m,
   input  logic        memwrite_m,
   input  logic [31:0] aluresult_m,
   input  logic [31:0] writedata_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] rd,
   output logic        stall_f,
   output logic        stall_d,
   output logic        stall_e,
   output logic        stall_m,
   output logic        flush_w,
   output logic        busy,
   output logic [15:0] stall_cycles,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        access_s;
   logic        req_raw_s;
   logic        req_s;

`ifdef MEM_TIMEOUT_EN
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        err_q, err_d;
`else
   // Parameter is only meaningful with the timeout feature.
   logic unused_cfg_s;
   assign unused_cfg_s = ^32'(TIMEOUT_CYCLES);
`endif

   assign access_s = memread_m | memwrite_m;

   // Next-state, request generation and load-data capture.
   always_comb begin
      state_d   = state_q;
      rdata_d   = rdata_q;
      req_raw_s = 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (access_s) begin
               req_raw_s = 1'b1;
               if (dmem_ack) begin
                  state_d = S_DONE;
                  if (!memwrite_m) begin
                     rdata_d = dmem_rdata;
                  end else begin
                     rdata_d = rdata_q;
                  end
               end else begin
                  state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt_d = 16'd0;
`endif
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            req_raw_s = 1'b1;
            if (dmem_ack) begin
               state_d = S_DONE;
               if (!memwrite_m) begin
                  rdata_d = dmem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
`ifdef MEM_TIMEOUT_EN
            end else if (wait_cnt_q == WAIT_LAST) begin
               // Abort: retire the instruction with zero data.
               state_d = S_DONE;
               rdata_d = 32'h0000_0000;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
`else
            end else begin
               state_d = S_WAIT;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Gate with rst_n so a reset drops the request in the same cycle even if
   // the M-stage still presents an access.
   assign req_s = rst_n & req_raw_s;

   // Saturating stall-cycle counter.
   always_comb begin
      if (req_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State and data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rdata_q     <= 32'h0000_0000;
         stall_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // WAIT-cycle counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= 16'h0000;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign dmem_req     = req_s;
   assign dmem_we      = req_s & memwrite_m;
   assign dmem_addr    = req_s ? aluresult_m : 32'h0000_0000;
   assign dmem_wdata   = req_s ? writedata_m : 32'h0000_0000;
   assign stall_f      = req_s;
   assign stall_d      = req_s;
   assign stall_e      = req_s;
   assign stall_m      = req_s;
   assign flush_w      = req_s;
   assign busy         = (state_q != S_IDLE);
   assign rd           = rdata_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
module tb_mem_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memread_m = 1'b0;
   logic        memwrite_m = 1'b0;
   logic [31:0] aluresult_m = 32'h0;
   logic [31:0] writedata_m = 32'h0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;
   logic [31:0] rd;
   logic        stall_f, stall_d, stall_e, stall_m, flush_w, busy, err;
   logic [15:0] stall_cycles;

   int          errors = 0;
   int          checks = 0;

   // Reference state: last load result, total stalled cycles, sticky error.
   logic [31:0] exp_rd = 32'h0;
   int          exp_stall = 0;
   logic        exp_err = 1'b0;

   mem_stall_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .memread_m(memread_m), .memwrite_m(memwrite_m),
      .aluresult_m(aluresult_m), .writedata_m(writedata_m),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .rd(rd),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_w(flush_w), .busy(busy),
      .stall_cycles(stall_cycles), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   // One memory access acked after n wait cycles, followed by its DONE cycle.
   task automatic do_txn(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int n, input logic [31:0] rdat);
      memread_m = r; memwrite_m = w; aluresult_m = a; writedata_m = d;
      for (int i = 0; i <= n; i++) begin
         dmem_ack   = (i == n);
         dmem_rdata = (i == n) ? rdat : $urandom;
         #3;
         chk("req", {31'd0, dmem_req}, 32'd1);
         chk("stall", {27'd0, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h1F);
         chk("we", {31'd0, dmem_we}, {31'd0, w});
         chk("addr", dmem_addr, a);
         chk("wdata", dmem_wdata, d);
         chk("busy_req", {31'd0, busy}, (i == 0) ? 32'd0 : 32'd1);
         next_cycle();
      end
      if (!w) exp_rd = rdat;
      exp_stall += n + 1;
      // DONE: a stray ack with garbage data must be ignored.
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #3;
      chk("done_req", {31'd0, dmem_req}, 32'd0);
      chk("done_stall", {27'd0, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h0);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_rd", rd, exp_rd);
      chk("done_cnt", {16'd0, stall_cycles}, {16'd0, sat16(exp_stall)});
      chk("done_err", {31'd0, err}, {31'd0, exp_err});
      next_cycle();
   endtask

   // IDLE cycle with no access; a stray ack must be ignored.
   task automatic idle_cycle();
      memread_m = 1'b0; memwrite_m = 1'b0;
      aluresult_m = $urandom; writedata_m = $urandom;
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      #3;
      chk("idle_out", {25'd0, dmem_req, dmem_we, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h0);
      chk("idle_addr", dmem_addr | dmem_wdata, 32'h0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_rd", rd, exp_rd);
      chk("idle_err", {31'd0, err}, {31'd0, exp_err});
      next_cycle();
   endtask

   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_rd"}, rd, 32'h0);
      chk({tag, "_cnt"}, {16'd0, stall_cycles}, 32'h0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      exp_rd = 32'h0; exp_stall = 0; exp_err = 1'b0;
      memread_m = 1'b0; memwrite_m = 1'b0; dmem_ack = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      apply_reset("reset");
      idle_cycle();

      // Zero-wait load.
      do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h8765_4321);
      idle_cycle();

      // Wait-state store after a fresh reset: stall count must read 4.
      apply_reset("reset2");
      idle_cycle();
      do_txn(1'b0, 1'b1, 32'h0000_0040, 32'hFFF0_F0FF, 3, 32'h1234_5678);
      chk("store_cnt", {16'd0, stall_cycles}, 32'd4);
      chk("store_rd", rd, 32'h0);
      idle_cycle();

      // Simultaneous read and write behaves as a write.
      do_txn(1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_5A5A, 1, 32'hDEAD_BEEF);

      // Back-to-back loads.
      do_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h1111_1111);
      do_txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h2222_2222);
      idle_cycle();

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         int kind;
         kind = $urandom_range(0, 2);
         do_txn(kind != 1, kind != 0, $urandom, $urandom, $urandom_range(0, 5), $urandom);
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end

`ifdef MEM_TIMEOUT_EN
      // Load never acked: 1 IDLE request cycle plus 16 WAIT cycles.
      memread_m = 1'b1; memwrite_m = 1'b0; aluresult_m = 32'h200;
      for (int i = 0; i < 17; i++) begin
         dmem_ack = 1'b0;
         #3;
         chk("to_req", {31'd0, dmem_req}, 32'd1);
         chk("to_err0", {31'd0, err}, 32'd0);
         next_cycle();
      end
      exp_stall += 17; exp_rd = 32'h0; exp_err = 1'b1;
      #3;
      chk("to_done_req", {31'd0, dmem_req}, 32'd0);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_rd", rd, 32'h0);
      chk("to_busy", {31'd0, busy}, 32'd1);
      next_cycle();
      idle_cycle();
      idle_cycle();
`else
      chk("err_tied", {31'd0, err}, 32'd0);
`endif

      // Reset in the middle of WAIT with the access still presented.
      memread_m = 1'b1; memwrite_m = 1'b0; aluresult_m = 32'h300;
      dmem_ack = 1'b0;
      next_cycle();
      next_cycle();
      #2;
      chk("midwait_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rd", rd, 32'h0);
      chk("rst_cnt", {16'd0, stall_cycles}, 32'h0);
      chk("rst_err", {31'd0, err}, 32'd0);
      exp_rd = 32'h0; exp_stall = 0; exp_err = 1'b0;
      memread_m = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      idle_cycle();
      do_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2, 32'hCAFE_F00D);
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
